// File: rtl/uart_bus_decoder.sv
// rtl/uart_bus_decoder.sv - Bus-to-UART register decoder with per-channel transmit sequencer
module uart_bus_decoder #(
  parameter int         NUM_CH     = 2,
  parameter logic [3:0] BASE_NIB   = 4'h2,
  parameter int         TX_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic                rvalid_o,
  output logic                err_o,
  output logic [8*NUM_CH-1:0] tx_data_o,
  output logic [NUM_CH-1:0]   tx_start_o,
  input  logic [NUM_CH-1:0]   tx_busy_i,
  input  logic [8*NUM_CH-1:0] rx_data_i,
  input  logic [NUM_CH-1:0]   rx_valid_i
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} tx_state_e;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_TXDATA = 4'h8;
  localparam logic [3:0] OFF_RXDATA = 4'hC;
  localparam logic [3:0] NUM_CH_L   = 4'(NUM_CH);
  localparam int         CNT_W      = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

  logic [3:0] ch;
  logic [3:0] off;
  logic       hit;
  logic       access;
  logic       off_ok;
  logic       ch_ok;
  logic       acc_ok;
  logic       acc_bad;
  logic [4*NUM_CH-1:0] ctrl_flat;
  logic [8*NUM_CH-1:0] rx_flat;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign ch      = addr_i[11:8];
  assign off     = addr_i[3:0];
  assign hit     = (addr_i[15:12] == BASE_NIB) && (addr_i[7:4] == 4'h1);
  assign access  = we_i | re_i;
  assign off_ok  = (off == OFF_CTRL) || (off == OFF_TXDATA) || (off == OFF_RXDATA);
  assign ch_ok   = ch < NUM_CH_L;
  assign acc_ok  = hit & access & off_ok & ch_ok;
  assign acc_bad = hit & access & ~(off_ok & ch_ok);

  assign unused_bits = ^{addr_i[31:16], wdata_i[31:8]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(c);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             send_q;
    logic             new_rx_q;
    logic             txerr_q;
    logic             overrun_q;
    logic [7:0]       txd_q;
    logic [7:0]       rxd_q;
    logic             sel;
    logic             wr_ctrl;
    logic             wr_txd;
    logic             start_pulse;
    logic             timeout;
    logic             done;

    assign sel     = acc_ok & we_i & (ch == CH_IDX);
    assign wr_ctrl = sel & (off == OFF_CTRL);
    assign wr_txd  = sel & (off == OFF_TXDATA);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:      if (send_q) state_d = S_START;
        S_START:     state_d = S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (tx_busy_i[c])              state_d = S_WAIT_DONE;
          else if (cnt_q == CNT_LAST)    state_d = S_IDLE;
        end
        S_WAIT_DONE: if (!tx_busy_i[c]) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end

    always_comb begin
      start_pulse = 1'b0;
      timeout     = 1'b0;
      done        = 1'b0;
      case (state_q)
        S_START:     start_pulse = 1'b1;
        S_WAIT_BUSY: timeout     = !tx_busy_i[c] && (cnt_q == CNT_LAST);
        S_WAIT_DONE: done        = !tx_busy_i[c];
        default:     ;
      endcase
    end

    // Hardware set/clear events take priority over software writes to the same bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q     <= '0;
        send_q    <= 1'b0;
        new_rx_q  <= 1'b0;
        txerr_q   <= 1'b0;
        overrun_q <= 1'b0;
        txd_q     <= 8'h00;
        rxd_q     <= 8'h00;
      end else begin
        cnt_q <= (state_q == S_WAIT_BUSY) ? cnt_q + 1'b1 : '0;

        if (timeout || done)                                  send_q <= 1'b0;
        else if (wr_ctrl && wdata_i[0] && state_q == S_IDLE)  send_q <= 1'b1;

        if (timeout)                        txerr_q <= 1'b1;
        else if (wr_ctrl && wdata_i[2])     txerr_q <= 1'b0;

        if (rx_valid_i[c])                  new_rx_q <= 1'b1;
        else if (wr_ctrl && !wdata_i[1])    new_rx_q <= 1'b0;

        if (rx_valid_i[c] && new_rx_q)      overrun_q <= 1'b1;
        else if (wr_ctrl && wdata_i[3])     overrun_q <= 1'b0;

        if (rx_valid_i[c])                  rxd_q <= rx_data_i[8*c +: 8];
        if (wr_txd && state_q == S_IDLE)    txd_q <= wdata_i[7:0];
      end
    end

    assign ctrl_flat[4*c +: 4] = {overrun_q, txerr_q, new_rx_q, send_q};
    assign rx_flat[8*c +: 8]   = rxd_q;
    assign tx_data_o[8*c +: 8] = txd_q;
    assign tx_start_o[c]       = start_pulse;
  end

  always_comb begin
    rd_mux = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 4'(c)) begin
        case (off)
          OFF_CTRL:   rd_mux = {28'h0, ctrl_flat[4*c +: 4]};
          OFF_TXDATA: rd_mux = {24'h0, tx_data_o[8*c +: 8]};
          OFF_RXDATA: rd_mux = {24'h0, rx_flat[8*c +: 8]};
          default:    rd_mux = 32'h0;
        endcase
      end
    end
  end

  // Read data is sampled from current state, so a same-cycle write returns the old value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_o  <= 32'h0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= acc_ok & re_i;
      rdata_o  <= (acc_ok & re_i) ? rd_mux : 32'h0;
      err_o    <= acc_bad;
    end
  end

endmodule

// File: tb/tb_uart_bus_decoder.sv
// tb/tb_uart_bus_decoder.sv - Directed self-checking bench for uart_bus_decoder
module tb_uart_bus_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic [15:0] tx_data;
  logic [1:0]  tx_start;
  logic [1:0]  tx_busy;
  logic [15:0] rx_data;
  logic [1:0]  rx_valid;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt0  = 0;
  int start_cnt1  = 0;

  logic [31:0] r_data;
  logic        r_valid;
  logic        r_err;

  uart_bus_decoder #(
    .NUM_CH     (2),
    .BASE_NIB   (4'h2),
    .TX_TIMEOUT (16)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .addr_i     (addr),
    .we_i       (we),
    .re_i       (re),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .rvalid_o   (rvalid),
    .err_o      (err),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .tx_busy_i  (tx_busy),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (tx_start[0]) start_cnt0++;
    if (tx_start[1]) start_cnt1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
    r_data = rdata; r_valid = rvalid; r_err = err;
  endtask

  task automatic wait_start0(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (tx_start[0]) seen = 1'b1;
    end
    check(tag, {31'h0, seen}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; addr = 32'h0; we = 1'b0; re = 1'b0; wdata = 32'h0;
    tx_busy = 2'b00; rx_data = 16'h0; rx_valid = 2'b00;
    r_data = 32'h0; r_valid = 1'b0; r_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {rdata[15:0], 7'h0, rvalid, err, tx_start, tx_data[6:0]}, 32'h0);
    check("reset_txdata", {16'h0, tx_data}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic transmit on channel 0
    bus(1, 0, 32'h2018, 32'h41);
    check("txdata_latch", {24'h0, tx_data[7:0]}, 32'h41);
    bus(1, 0, 32'h2010, 32'h1);
    wait_start0("tx_start_seen");
    repeat (3) @(posedge clk);
    #1 tx_busy[0] = 1'b1;
    bus(1, 0, 32'h2018, 32'h99);
    check("txdata_locked", {24'h0, tx_data[7:0]}, 32'h41);
    bus(0, 1, 32'h2010, 32'h0);
    check("ctrl_while_busy", r_data, 32'h1);
    repeat (2) @(posedge clk);
    #1 tx_busy[0] = 1'b0;
    @(posedge clk); #1;
    bus(0, 1, 32'h2010, 32'h0);
    check("ctrl_after_done", r_data, 32'h0);
    check("ctrl_after_done_rvalid", {31'h0, r_valid}, 32'h1);
    bus(0, 1, 32'h2018, 32'h0);
    check("txdata_readback", r_data, 32'h41);
    check("start_count_one", start_cnt0, 32'd1);

    // Receive on channel 1
    #1 rx_data[15:8] = 8'h5A; rx_valid = 2'b10;
    @(posedge clk); #1;
    rx_valid = 2'b00;
    bus(0, 1, 32'h211C, 32'h0);
    check("rxdata_ch1", r_data, 32'h5A);
    check("rxdata_ch1_rvalid", {31'h0, r_valid}, 32'h1);
    bus(0, 1, 32'h2110, 32'h0);
    check("ctrl_ch1_newrx", r_data, 32'h2);
    bus(0, 1, 32'h2010, 32'h0);
    check("ctrl_ch0_untouched", r_data, 32'h0);
    bus(1, 0, 32'h2110, 32'h0);
    bus(0, 1, 32'h2110, 32'h0);
    check("ctrl_ch1_cleared", r_data, 32'h0);

    // Simultaneous read and write returns the old value
    bus(1, 1, 32'h2118, 32'h77);
    check("rw_old_value", r_data, 32'h0);
    bus(0, 1, 32'h2118, 32'h0);
    check("rw_new_value", r_data, 32'h77);

    // Overrun on channel 0
    rx_data[7:0] = 8'h11; rx_valid = 2'b01;
    @(posedge clk); #1;
    rx_data[7:0] = 8'h22;
    @(posedge clk); #1;
    rx_valid = 2'b00;
    bus(0, 1, 32'h2010, 32'h0);
    check("ctrl_overrun", r_data, 32'hA);
    bus(0, 1, 32'h201C, 32'h0);
    check("rxdata_last", r_data, 32'h22);
    bus(1, 0, 32'h2010, 32'h8);
    bus(1, 0, 32'h2010, 32'h0);
    bus(0, 1, 32'h2010, 32'h0);
    check("ctrl_overrun_cleared", r_data, 32'h0);

    // Hardware set beats a same-cycle software clear
    rx_data[7:0] = 8'h33; rx_valid = 2'b01;
    @(posedge clk); #1;
    rx_valid = 2'b00;
    rx_data[7:0] = 8'h44; rx_valid = 2'b01;
    bus(1, 0, 32'h2010, 32'h8);
    rx_valid = 2'b00;
    bus(0, 1, 32'h2010, 32'h0);
    check("hw_set_wins", r_data, 32'hA);
    bus(1, 0, 32'h2010, 32'h8);
    bus(0, 1, 32'h2010, 32'h0);
    check("hw_set_cleared", r_data, 32'h0);

    // Transmit timeout with busy never rising
    bus(1, 0, 32'h2010, 32'h1);
    repeat (17) @(posedge clk);
    #1;
    bus(0, 1, 32'h2010, 32'h0);
    check("timeout_last_busy_cycle", r_data, 32'h1);
    bus(0, 1, 32'h2010, 32'h0);
    check("timeout_txerr", r_data, 32'h4);
    bus(1, 0, 32'h2010, 32'h4);
    bus(0, 1, 32'h2010, 32'h0);
    check("txerr_cleared", r_data, 32'h0);
    check("start_count_two", start_cnt0, 32'd2);

    // Bad accesses inside and outside the region
    bus(0, 1, 32'h2014, 32'h0);
    check("bad_offset", {30'h0, r_err, r_valid}, 32'h2);
    bus(0, 1, 32'h2210, 32'h0);
    check("bad_channel", {30'h0, r_err, r_valid}, 32'h2);
    bus(0, 1, 32'h3010, 32'h0);
    check("non_hit", {30'h0, r_err, r_valid}, 32'h0);
    bus(1, 0, 32'h2014, 32'hFF);
    check("bad_write_err", {31'h0, r_err}, 32'h1);
    bus(0, 1, 32'h2010, 32'h0);
    check("bad_write_no_effect", {r_data[30:0], r_err}, 32'h0);

    // Reset during WAIT_DONE
    bus(1, 0, 32'h2010, 32'h1);
    wait_start0("tx_start_seen_2");
    repeat (3) @(posedge clk);
    #1 tx_busy[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus(0, 1, 32'h2018, 32'h0);
    check("pre_reset_read", r_data, 32'h41);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rdata", rdata, 32'h0);
    check("async_reset_flags", {28'h0, rvalid, err, tx_start}, 32'h0);
    check("async_reset_txdata", {16'h0, tx_data}, 32'h0);
    @(posedge clk); #1;
    tx_busy[0] = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_start_after_reset", start_cnt0, 32'd3);
    bus(0, 1, 32'h2010, 32'h0);
    check("ctrl_after_reset", r_data, 32'h0);
    check("ch1_never_started", start_cnt1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_bus_decoder.md
UART_BUS_DECODER -- requirements
Module: uart_bus_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, range 1..4: number of UART channels served.
REQ-002 SHALL have parameter BASE_NIB, default 4'h2: required value of addr_i[15:12].
REQ-003 SHALL have parameter TX_TIMEOUT, default 16: cycles allowed in WAIT_BUSY for tx_busy_i to rise.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports below, clock and reset first.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_n_i  in  1  asynchronous active-low reset.
REQ-007 addr_i  in  32  bus address from ALU.
REQ-008 we_i / re_i  in  1 each  write / read strobe, one cycle per access.
REQ-009 wdata_i  in  32  write data.
REQ-010 rdata_o  out  32  registered read data; rvalid_o  out  1  read-data-valid pulse.
REQ-011 err_o  out  1  registered pulse on a bad access inside the UART region.
REQ-012 tx_data_o  out  8*NUM_CH  per-channel TX byte; tx_start_o  out  NUM_CH  per-channel start pulse.
REQ-013 tx_busy_i  in  NUM_CH  transmitter busy; rx_data_i  in  8*NUM_CH; rx_valid_i  in  NUM_CH  one-cycle RX pulse.

Function
REQ-014 Region hit SHALL be addr_i[15:12]==BASE_NIB and addr_i[7:4]==4'h1; channel index ch = addr_i[11:8].
REQ-015 Offsets addr_i[3:0]: 0x0 CTRL, 0x8 TXDATA, 0xC RXDATA; any other offset, or ch>=NUM_CH, on a hit with we_i|re_i SHALL pulse err_o next cycle and have no side effect.
REQ-016 CTRL bits: [0] SEND, [1] NEW_RX, [2] TXERR, [3] OVERRUN; bits [31:4] read 0.
REQ-017 CTRL write: wdata[0]=1 sets SEND only when channel FSM is IDLE (else ignored); wdata[1]=0 clears NEW_RX; wdata[2]=1 clears TXERR; wdata[3]=1 clears OVERRUN.
REQ-018 TXDATA write SHALL latch wdata_i[7:0] into tx_data_o only while FSM is IDLE; otherwise ignored, no err_o.
REQ-019 rx_valid_i[c] SHALL latch rx_data_i byte into RXDATA[c] and set NEW_RX; if NEW_RX already set, SHALL also set OVERRUN.
REQ-020 Simultaneous rx_valid_i and CTRL write clearing NEW_RX/OVERRUN: hardware set SHALL win.
REQ-021 Per-channel FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE->START when SEND is 1; START: tx_start_o[c]=1 for exactly one cycle, then WAIT_BUSY.
REQ-023 WAIT_BUSY->WAIT_DONE when tx_busy_i[c]=1; after TX_TIMEOUT cycles without it, ->IDLE, clear SEND, set TXERR.
REQ-024 WAIT_DONE->IDLE when tx_busy_i[c]=0, clearing SEND in the same edge.
REQ-025 Read: re_i on valid hit SHALL drive rdata_o (RXDATA zero-extended, TXDATA zero-extended, CTRL) with rvalid_o=1 on the next cycle; otherwise rdata_o=0, rvalid_o=0.
REQ-026 re_i and we_i together: write SHALL take effect; read SHALL return the pre-write value.
REQ-027 Non-hit accesses SHALL produce no side effect, no err_o, no rvalid_o.
REQ-028 Channels SHALL operate independently and concurrently.

Reset
REQ-029 rst_n_i low SHALL immediately force all FSMs to IDLE, CTRL/TXDATA/RXDATA to 0, rdata_o=0, rvalid_o=0, err_o=0, tx_start_o=0, tx_data_o=0.
REQ-030 Reset mid-transmission SHALL abandon the send without a further tx_start_o pulse; first valid edge after release resumes normal operation.

Verification
REQ-031 Write 0x41 to 0x2018, write 1 to 0x2010, tx_busy_i[0] high 3 cycles after start then low -> tx_data_o[7:0]=0x41, one tx_start_o[0] pulse, CTRL read 0x0 after busy falls.
REQ-032 rx_valid_i[1] with 0x5A, read 0x211C, then read 0x2110 -> rdata_o=0x5A with rvalid_o next cycle; CTRL=0x2.
REQ-033 Two rx_valid_i[0] pulses without clear -> CTRL[0]=0xA; write 0x8 then 0x0 -> CTRL=0x0.
REQ-034 SEND with tx_busy_i held low -> FSM back to IDLE after 16 cycles in WAIT_BUSY, CTRL=0x4; write 0x4 -> 0x0.
REQ-035 Read 0x2014 and read 0x2210 with NUM_CH=2 -> err_o pulse each, rvalid_o=0; read 0x3010 -> no err_o.
REQ-036 Assert rst_n_i low during WAIT_DONE -> all outputs 0 within the same cycle, no tx_start_o after release.
